// File: rtl/inst_sram_responder.sv
// -----------------------------------------------------------------------------
// inst_sram_responder
//
// Accepts instruction-side SRAM requests (valid / addr_ok handshake) into a
// two-entry in-order queue and services them one at a time against a
// synchronous single-port RAM. Each request gets exactly one inst_data_ok
// pulse, in acceptance order.
//
// Service sequence per entry: IDLE -> [WAIT x WAIT_CYCLES] -> ACCESS -> RESP.
// ACCESS drives the RAM for one cycle; RESP returns the RAM read data
// (registered by the RAM) and retires the queue head.
//
// Optional feature (compile-time macro SRAM_RESP_ALIGN_CHK_EN):
//   defined   - misaligned halfword/word entries and size 3 skip the RAM access
//               and respond with zero data.
//   undefined - no alignment check; size 3 behaves as a word access and
//               halfword byte enables are truncated to 4 bits.
//
// Parameters:
//   ADDR_W      word-address width of the backing RAM
//   WAIT_CYCLES wait states before each RAM access (0..15)
//   DEPTH       outstanding-request limit (the queue is built for 2)
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   inst_req/wr/size/addr/wdata   request from the initiator
//   inst_addr_ok      request accepted this cycle (combinational)
//   inst_data_ok      one-cycle response pulse
//   inst_rdata        read data, zero unless responding to a read
//   mem_en/we/addr/wdata          backing RAM command
//   mem_rdata         RAM read data, valid the cycle after mem_en
// -----------------------------------------------------------------------------
module inst_sram_responder #(
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 0,
  parameter int DEPTH       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [31:0]       inst_addr,
  input  logic [31:0]       inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Only the address bits the RAM needs are stored.
  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [1:0]        off;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
  } entry_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic       HAS_WAIT  = (WAIT_CYCLES > 0) ? 1'b1 : 1'b0;
  localparam logic [1:0] DEPTH_C   = 2'(DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [1:0]  count_q, count_d;
  entry_t      q_q [2];
  entry_t      q_d [2];
  entry_t      head;
  entry_t      new_entry;
  logic        push;
  logic        pop;
  logic        skip;
  logic [3:0]  head_mask;
  logic        addr_hi_unused;

  // Byte-lane enables; the shift result is deliberately truncated to 4 bits.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001 << off;
      2'd1:    m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

`ifdef SRAM_RESP_ALIGN_CHK_EN
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = off[0];
      2'd2:    bad = (off != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign skip = misaligned(head.size, head.off);
`else
  assign skip = 1'b0;
`endif

  assign head           = q_q[0];
  assign head_mask      = byte_mask(head.size, head.off);
  assign addr_hi_unused = ^inst_addr[31:ADDR_W+2];
  assign new_entry      = '{wr: inst_wr, size: inst_size, off: inst_addr[1:0],
                            waddr: inst_addr[ADDR_W+1:2], wdata: inst_wdata};

  // Acceptance looks only at the registered count, never at a same-cycle pop,
  // and is forced low while reset is asserted.
  assign inst_addr_ok = rst & inst_req & (count_q < DEPTH_C);
  assign push         = inst_addr_ok;
  assign pop          = (state_q == ST_RESP);

  // Queue next-state: pop shifts entry 1 into the head, push lands behind.
  always_comb begin
    q_d     = q_q;
    count_d = count_q;
    if (pop) begin
      q_d[0]  = q_q[1];
      count_d = count_q - 2'd1;
    end else begin
      count_d = count_q;
    end
    if (push) begin
      if (pop) begin
        q_d[0] = new_entry;
      end else begin
        q_d[count_q[0]] = new_entry;
      end
      count_d = count_d + 2'd1;
    end else begin
      count_d = count_d;
    end
  end

  // Service FSM next-state; RESP re-arms from the post-pop/post-push count so
  // back-to-back entries run at one response per 2+WAIT_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (((state_q == ST_IDLE) ? count_q : count_d) != 2'd0) begin
          if (HAS_WAIT) begin
            state_d = ST_WAIT;
            wait_d  = WAIT_LOAD;
          end else begin
            state_d = ST_ACCESS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_q == 4'd0) begin
          state_d = ST_ACCESS;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode from the registered state and queue head.
  always_comb begin
    inst_data_ok = (state_q == ST_RESP);
    inst_rdata   = 32'h0;
    mem_en       = 1'b0;
    mem_we       = 4'b0000;
    mem_addr     = '0;
    mem_wdata    = 32'h0;
    if ((state_q == ST_ACCESS) && !skip) begin
      mem_en    = 1'b1;
      mem_we    = head.wr ? head_mask : 4'b0000;
      mem_addr  = head.waddr;
      mem_wdata = head.wdata;
    end else begin
      mem_en = 1'b0;
    end
    if ((state_q == ST_RESP) && !head.wr && !skip) begin
      inst_rdata = mem_rdata;
    end else begin
      inst_rdata = 32'h0;
    end
  end

  // State, wait counter and queue registers; reset drops all in-flight work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wait_q  <= 4'd0;
      count_q <= 2'd0;
      q_q[0]  <= '0;
      q_q[1]  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      q_q[0]  <= q_d[0];
      q_q[1]  <= q_d[1];
    end
  end

endmodule
